booth_radix4_mult: RTL

Parametrised, sequential radix-4 Booth multiplier with a start/valid handshake and per-operation signed/unsigned mode. It is the next-generation replacement for the fixed 4-bit radix-2 Booth core. It retires two multiplier bits per cycle and sits wherever the datapath needs a small-area, multi-cycle multiply. The result is registered and held until the next operation completes.

---
 rtl/booth_radix4_mult.sv | 78 +++++++
 1 files changed

// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult: sequential radix-4 Booth multiplier, two multiplier bits per cycle,
// signed/unsigned per operation, start/valid handshake with a held result.
module booth_radix4_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   Z
);
    localparam int E  = WIDTH + 2;
    localparam int N  = E / 2;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_next;
    logic [E-1:0]    r_m;
    logic [E+1:0]    r_a;
    logic [E:0]      r_q;
    logic [CW-1:0]   r_cnt;
    logic            w_accept, w_last;
    logic [E-1:0]    w_x_ext, w_y_ext;
    logic [E+1:0]    w_op, w_sum;
    logic [2*E+2:0]  w_sh;

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_cnt == CW'(N - 1));
    assign w_x_ext  = {{2{signed_mode & X[WIDTH-1]}}, X};
    assign w_y_ext  = {{2{signed_mode & Y[WIDTH-1]}}, Y};
    // Booth digit magnitude; the sign comes from q[2] via invert-plus-carry
    assign w_op  = (r_q[2:0] == 3'b011 || r_q[2:0] == 3'b100) ? {r_m[E-1], r_m, 1'b0} :
                   (r_q[2:0] == 3'b000 || r_q[2:0] == 3'b111) ? '0 : {{2{r_m[E-1]}}, r_m};
    assign w_sum = r_a + (r_q[2] ? ~w_op : w_op) + {{(E+1){1'b0}}, r_q[2]};
    assign w_sh  = {{2{w_sum[E+1]}}, w_sum, r_q[E:2]};
    assign busy  = (r_state == RUN);
    assign valid = (r_state == DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            default: w_next = start ? RUN : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m   <= '0;
            r_a   <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            Z     <= '0;
        end else if (w_accept) begin
            r_m   <= w_x_ext;
            r_a   <= '0;
            r_q   <= {w_y_ext, 1'b0};
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= w_sh[2*E+2:E+1];
            r_q   <= w_sh[E:0];
            r_cnt <= r_cnt + CW'(1);
            // low 2*WIDTH bits of {A,Q[E:1]} after the final shift
            if (w_last) Z <= w_sh[2*WIDTH:1];
        end
    end
endmodule
